// File: rtl/rv32i_imem_boot_ctrl.sv
// Boot loader for the rv32i instruction memory: takes a length-prefixed byte stream,
// writes little-endian words into the memory and holds the core stalled until the load is complete.
module rv32i_imem_boot_ctrl #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [31:0]       pc_addr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              fetch_misalign,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              core_stall,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        state_dbg
);

   // Stream handshake: a byte moves on a rising clk edge where rx_valid & rx_ready are both 1;
   // rx_ready depends only on state, never on rx_valid.

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DATA = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

   state_t            state, state_n;
   logic [1:0]        byte_cnt;
   logic [23:0]       hdr_q;
   logic [LEN_W-1:0]  len_q;
   logic [ADDR_W:0]   word_cnt;
   logic              hs;
   logic              start_ok;
   logic              last_byte;
   logic [31:0]       hdr_full;
   logic              hdr_bad;
   logic              hdr_zero;
   logic              last_word_written;

   assign hs        = rx_valid & rx_ready;
   assign last_byte = hs && (byte_cnt == 2'd3);
   assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign hdr_full  = {rx_data, hdr_q};

   // Length must fit in LEN_W bits and must not exceed the memory depth.
   assign hdr_bad  = ((hdr_full >> LEN_W) != 32'd0) || ({1'b0, hdr_full} > DEPTH);
   assign hdr_zero = (hdr_full == 32'd0);

   // word_cnt already points past the word being written while mem_we is high.
   assign last_word_written = mem_we && (LEN_W'(word_cnt) == len_q);

   assign mem_raddr      = pc_addr[ADDR_W+1:2];
   assign fetch_misalign = (state == S_DONE) && (pc_addr[1:0] != 2'b00);
   assign state_dbg      = state;

   logic unused_pc_bits;
   assign unused_pc_bits = &{1'b0, pc_addr[31:ADDR_W+2]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      rx_ready   = 1'b0;
      core_stall = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_n = S_HDR;
         end
         S_HDR: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (last_byte) begin
               if (hdr_bad)       state_n = S_ERR;
               else if (hdr_zero) state_n = S_DONE;
               else               state_n = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (last_word_written) state_n = S_DONE;
         end
         S_DONE: begin
            core_stall = 1'b0;
            done       = 1'b1;
            if (start) state_n = S_HDR;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_n = S_HDR;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt  <= 2'd0;
         hdr_q     <= 24'd0;
         len_q     <= '0;
         word_cnt  <= '0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (start_ok) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            hdr_q    <= 24'd0;
         end else if (hs) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_HDR) begin
               // Bytes arrive LSB first; the fourth is consumed directly from rx_data.
               hdr_q <= {rx_data, hdr_q[23:8]};
               if (last_byte) len_q <= hdr_full[LEN_W-1:0];
            end else begin
               case (byte_cnt)
                  2'd0:    mem_wdata[7:0]   <= rx_data;
                  2'd1:    mem_wdata[15:8]  <= rx_data;
                  2'd2:    mem_wdata[23:16] <= rx_data;
                  default: mem_wdata[31:24] <= rx_data;
               endcase
               if (last_byte) begin
                  mem_we    <= 1'b1;
                  mem_waddr <= word_cnt[ADDR_W-1:0];
                  word_cnt  <= word_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule
